// File: rtl/data_memory_ls.sv
// Byte-addressed little-endian data memory with a valid/ready request port, WAIT_CYCLES wait
// states and error responses. Define DMEM_PERF_CNT_EN to add rd/wr/err access counters.
module data_memory_ls #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0,
  parameter int TEST_INDEX  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [DATA_WIDTH-1:0] test_value
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count,
  output logic [15:0]           err_count
`endif
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SEL_W-1:0] TEST_SEL = SEL_W'(TEST_INDEX);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("data_memory_ls: DATA_WIDTH must be 32");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_check
    $error("data_memory_ls: WAIT_CYCLES must be 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state, state_next;
  logic [3:0]            cnt, cnt_next;
  logic                  accept, enter_resp;

  logic                  write_p0, unsigned_p0;
  logic [1:0]            size_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [31:0]           wdata_p0;

  logic                  eff_write, eff_unsigned;
  logic [1:0]            eff_size;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [31:0]           eff_wdata;

  logic [IDX_W-1:0]      idx;
  logic [1:0]            lane;
  logic [SEL_W-1:0]      sel;
  logic [31:0]           cur_word, store_word, load_word;
  logic                  acc_err;

  logic [31:0]           mem [DEPTH];

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] ln, input logic uns);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext;
    b   = word[8*ln +: 8];
    h   = ln[1] ? word[31:16] : word[15:0];
    b_s = b;
    h_s = h;
    ext = '0;
    case (size)
      2'b00:   ext = uns ? signed'({24'b0, b}) : 32'(b_s);
      2'b01:   ext = uns ? signed'({16'b0, h}) : 32'(h_s);
      default: ext = signed'(word);
    endcase
    return unsigned'(ext);
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] ln);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00:   r[8*ln +: 8] = wd[7:0];
      2'b01:   if (ln[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_next = S_WAIT;
            cnt_next   = 4'(WAIT_CYCLES);
          end else begin
            state_next = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt <= 4'd1) begin
          state_next = S_RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_RESP: begin
        rsp_valid  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign enter_resp = (state_next == S_RESP) && (state != S_RESP);

  // With no wait states the access completes on the accept edge, so decode straight from the inputs.
  always_comb begin
    if (state == S_IDLE) begin
      eff_write    = req_write;
      eff_size     = req_size;
      eff_unsigned = req_unsigned;
      eff_addr     = req_addr;
      eff_wdata    = req_wdata;
    end else begin
      eff_write    = write_p0;
      eff_size     = size_p0;
      eff_unsigned = unsigned_p0;
      eff_addr     = addr_p0;
      eff_wdata    = wdata_p0;
    end
  end

  assign idx        = eff_addr[ADDR_WIDTH-1:2];
  assign lane       = eff_addr[1:0];
  assign sel        = idx[SEL_W-1:0];
  assign cur_word   = mem[sel];
  assign acc_err    = (eff_size == 2'b11)
                    | ((eff_size == 2'b01) & lane[0])
                    | ((eff_size == 2'b10) & (lane != 2'b00))
                    | (idx >= IDX_W'(DEPTH));
  assign store_word = store_merge(cur_word, eff_wdata, eff_size, lane);
  assign load_word  = load_ext(cur_word, eff_size, lane, eff_unsigned);
  assign test_value = mem[TEST_SEL];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (enter_resp) begin
        rsp_error <= acc_err;
        rsp_rdata <= (eff_write || acc_err) ? '0 : load_word;
      end
    end
  end

  // Request capture stage
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0    <= req_write;
      size_p0     <= req_size;
      unsigned_p0 <= req_unsigned;
      addr_p0     <= req_addr;
      wdata_p0    <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enter_resp && eff_write && !acc_err) begin
      mem[sel] <= store_word;
    end
  end

`ifdef DMEM_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (state == S_RESP) begin
      if (rsp_error)     err_count <= sat_inc(err_count);
      else if (write_p0) wr_count  <= sat_inc(wr_count);
      else               rd_count  <= sat_inc(rd_count);
    end
  end
`endif

endmodule
